// File: rtl/wb_wr_arb.sv
// Register-file write-port arbiter: pipeline writeback vs long-latency unit, with
// same-rd WAW ordering, x0 suppression and starvation bound. Optional macro: WB_WR_ARB_PERF_EN.
module wb_wr_arb #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid_i,
  output logic              pipe_ready_o,
  input  logic [ADDR_W-1:0] pipe_rd_addr_i,
  input  logic [DATA_W-1:0] pipe_rd_data_i,
  input  logic              lu_valid_i,
  output logic              lu_ready_o,
  input  logic [ADDR_W-1:0] lu_rd_addr_i,
  input  logic [DATA_W-1:0] lu_rd_data_i,
  output logic              rf_wr_en_o,
  output logic [ADDR_W-1:0] rf_wr_addr_o,
  output logic [DATA_W-1:0] rf_wr_data_o,
  output logic              pipe_stall_o,
  output logic [31:0]       perf_stall_cnt_o
);

  typedef enum logic {PRI_PIPE, PRI_LU} pri_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  pri_e              state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pipe_gnt, lu_gnt, collide;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    pipe_gnt = 1'b0;
    lu_gnt   = 1'b0;
    // lu is the older instruction, so on a real rd clash it must write first.
    collide  = pipe_valid_i && lu_valid_i &&
               (pipe_rd_addr_i == lu_rd_addr_i) && (pipe_rd_addr_i != '0);
    if (!rst) begin
      if (collide) begin
        lu_gnt = 1'b1;
      end else if (state_q == PRI_LU) begin
        lu_gnt   = lu_valid_i;
        pipe_gnt = pipe_valid_i && !lu_valid_i;
      end else begin
        pipe_gnt = pipe_valid_i;
        lu_gnt   = lu_valid_i && !pipe_valid_i;
      end
    end
  end

  assign pipe_ready_o = pipe_gnt;
  assign lu_ready_o   = lu_gnt;
  assign pipe_stall_o = pipe_valid_i && !pipe_gnt;

  always_comb begin
    en_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    wait_d  = wait_q;
    state_d = state_q;
    if (pipe_gnt) begin
      en_d   = (pipe_rd_addr_i != '0);
      addr_d = pipe_rd_addr_i;
      data_d = pipe_rd_data_i;
    end else if (lu_gnt) begin
      en_d   = (lu_rd_addr_i != '0);
      addr_d = lu_rd_addr_i;
      data_d = lu_rd_data_i;
    end
    if (lu_gnt || !lu_valid_i) begin
      wait_d = '0;
    end else if (wait_q < STARVE_LIM) begin
      wait_d = wait_q + 4'd1;
    end
    case (state_q)
      PRI_PIPE: if (wait_q != STARVE_LIM && wait_d == STARVE_LIM) state_d = PRI_LU;
      PRI_LU:   if (lu_gnt || !lu_valid_i) state_d = PRI_PIPE;
      default:  state_d = PRI_PIPE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state_q <= PRI_PIPE;
      wait_q  <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign rf_wr_en_o   = en_q;
  assign rf_wr_addr_o = addr_q;
  assign rf_wr_data_o = data_q;

`ifdef WB_WR_ARB_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (pipe_stall_o) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = perf_q;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_wr_arb.sv
// Bench for wb_wr_arb: directed scenarios plus a randomized run against a
// cycle-level reference model of the arbitration rules.
module tb_wb_wr_arb;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pipe_valid = 1'b0, lu_valid = 1'b0;
  logic [ADDR_W-1:0] pipe_addr = '0, lu_addr = '0;
  logic [DATA_W-1:0] pipe_data = '0, lu_data = '0;
  logic              pipe_ready, lu_ready, rf_en, pipe_stall;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [31:0]       perf_cnt;

  int errors = 0;
  int checks = 0;

  wb_wr_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid_i(pipe_valid), .pipe_ready_o(pipe_ready),
    .pipe_rd_addr_i(pipe_addr), .pipe_rd_data_i(pipe_data),
    .lu_valid_i(lu_valid), .lu_ready_o(lu_ready),
    .lu_rd_addr_i(lu_addr), .lu_rd_data_i(lu_data),
    .rf_wr_en_o(rf_en), .rf_wr_addr_o(rf_addr), .rf_wr_data_o(rf_data),
    .pipe_stall_o(pipe_stall), .perf_stall_cnt_o(perf_cnt)
  );

  always #5 clk = ~clk;

`ifdef WB_WR_ARB_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pipe_valid = v; pipe_addr = a; pipe_data = d;
  endtask

  task automatic set_lu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    lu_valid = v; lu_addr = a; lu_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_pipe(1'b0, '0, '0);
    set_lu(1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_pipe(1'b1, 5'd4, 32'h1234);
    set_lu(1'b1, 5'd6, 32'h5678);
    tick();
    @(negedge clk);
    checks++;
    if (pipe_ready !== 1'b0 || lu_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got pipe=%b lu=%b, want 0/0", pipe_ready, lu_ready);
    end
    checks++;
    if (rf_en !== 1'b0 || rf_addr !== '0 || rf_data !== '0 || perf_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h perf=%0d, want 0/0/0/0",
               rf_en, rf_addr, rf_data, perf_cnt);
    end
    do_reset();
  endtask

  task automatic test_pipe_only();
    do_reset();
    set_pipe(1'b1, 5'd5, 32'h11);
    @(negedge clk);
    checks++;
    if (pipe_ready !== 1'b1 || pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL pipe_only_ready: got ready=%b stall=%b, want 1/0", pipe_ready, pipe_stall);
    end
    tick();
    set_pipe(1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (rf_en !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'h11) begin
      errors++;
      $display("FAIL pipe_only_write: got en=%b addr=%0d data=%h, want 1/5/11", rf_en, rf_addr, rf_data);
    end
  endtask

  task automatic test_starvation();
    bit prev_lu = 1'b0;
    do_reset();
    set_pipe(1'b1, 5'd3, 32'h33);
    set_lu(1'b1, 5'd7, 32'h77);
    for (int k = 0; k < 12; k++) begin
      bit want_lu;
      want_lu = ((k % (STARVE_MAX + 1)) == STARVE_MAX);
      @(negedge clk);
      checks++;
      if (lu_ready !== want_lu || pipe_ready !== !want_lu) begin
        errors++;
        $display("FAIL starve_grant[%0d]: got pipe=%b lu=%b, want pipe=%b lu=%b",
                 k, pipe_ready, lu_ready, !want_lu, want_lu);
      end
      if (k > 0) begin
        checks++;
        if (rf_en !== 1'b1 || rf_addr !== (prev_lu ? 5'd7 : 5'd3) ||
            rf_data !== (prev_lu ? 32'h77 : 32'h33)) begin
          errors++;
          $display("FAIL starve_write[%0d]: got addr=%0d data=%h, want lu_won=%b", k, rf_addr, rf_data, prev_lu);
        end
      end
      prev_lu = want_lu;
      tick();
    end
  endtask

  task automatic test_collision();
    do_reset();
    set_pipe(1'b1, 5'd9, 32'hAA);
    set_lu(1'b1, 5'd9, 32'hBB);
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b1 || pipe_ready !== 1'b0 || pipe_stall !== 1'b1) begin
      errors++;
      $display("FAIL collide_grant: got pipe=%b lu=%b stall=%b, want 0/1/1", pipe_ready, lu_ready, pipe_stall);
    end
    tick();
    set_lu(1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (rf_en !== 1'b1 || rf_data !== 32'hBB || pipe_ready !== 1'b1 || pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL collide_first: got en=%b data=%h pipe_ready=%b stall=%b, want 1/bb/1/0",
               rf_en, rf_data, pipe_ready, pipe_stall);
    end
    tick();
    set_pipe(1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (rf_en !== 1'b1 || rf_addr !== 5'd9 || rf_data !== 32'hAA) begin
      errors++;
      $display("FAIL collide_second: got en=%b addr=%0d data=%h, want 1/9/aa", rf_en, rf_addr, rf_data);
    end
  endtask

  task automatic test_x0();
    do_reset();
    set_lu(1'b1, 5'd0, 32'hFF);
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_lu_ready: got %b, want 1", lu_ready);
    end
    tick();
    set_pipe(1'b1, 5'd0, 32'h12);
    set_lu(1'b1, 5'd0, 32'h34);
    @(negedge clk);
    checks++;
    if (rf_en !== 1'b0 || rf_data !== 32'hFF) begin
      errors++;
      $display("FAIL x0_suppress: got en=%b data=%h, want 0/ff", rf_en, rf_data);
    end
    checks++;
    if (pipe_ready !== 1'b1 || lu_ready !== 1'b0) begin
      errors++;
      $display("FAIL x0_no_override: got pipe=%b lu=%b, want 1/0", pipe_ready, lu_ready);
    end
    tick();
    set_pipe(1'b0, '0, '0);
    set_lu(1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (rf_en !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'h12) begin
      errors++;
      $display("FAIL x0_pipe_write: got en=%b addr=%0d data=%h, want 0/0/12", rf_en, rf_addr, rf_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_pipe(1'b1, 5'd3, 32'h3);
    set_lu(1'b1, 5'd7, 32'h7);
    repeat (STARVE_MAX) tick();
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_pri_lu: got lu_ready=%b, want 1", lu_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (lu_ready !== 1'b0 || pipe_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_ready_forced: got pipe=%b lu=%b, want 0/0", pipe_ready, lu_ready);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_en !== 1'b0 || pipe_ready !== 1'b1 || lu_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_reset: got en=%b pipe=%b lu=%b, want 0/1/0", rf_en, pipe_ready, lu_ready);
    end
  endtask

  task automatic test_perf();
    do_reset();
    set_pipe(1'b1, 5'd1, 32'h1);
    set_lu(1'b1, 5'd1, 32'h2);
    repeat (6) tick();
    set_pipe(1'b0, '0, '0);
    set_lu(1'b0, '0, '0);
    tick();
    @(negedge clk);
    checks++;
    if (perf_cnt !== (PERF_ON ? 32'd6 : 32'd0)) begin
      errors++;
      $display("FAIL perf_count: got %0d, want %0d", perf_cnt, PERF_ON ? 6 : 0);
    end
  endtask

  // Reference model: lu gets priority once it has waited STARVE_MAX cycles.
  bit          m_lu_first;
  int          m_waited;
  bit          m_en;
  int unsigned m_addr, m_data, m_perf;

  task automatic test_random();
    bit p_pend = 0, l_pend = 0;
    do_reset();
    m_lu_first = 0; m_waited = 0; m_en = 0; m_addr = 0; m_data = 0; m_perf = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      bit gp, gl, want_stall, clash;
      rst = ($urandom % 64 == 0);
      if (!p_pend && $urandom % 4 != 0) begin
        p_pend = 1;
        set_pipe(1'b1, ADDR_W'($urandom % 6), $urandom);
      end
      if (l_pend && $urandom % 16 == 0) l_pend = 0;
      else if (!l_pend && $urandom % 2 == 0) begin
        l_pend = 1;
        set_lu(1'b1, ADDR_W'($urandom % 6), $urandom);
      end
      pipe_valid = p_pend;
      lu_valid   = l_pend;
      @(negedge clk);
      clash = p_pend && l_pend && pipe_addr == lu_addr && pipe_addr != 0;
      gp = 0; gl = 0;
      if (!rst) begin
        if (clash)           gl = 1;
        else if (m_lu_first) begin gl = l_pend; gp = p_pend && !l_pend; end
        else                 begin gp = p_pend; gl = l_pend && !p_pend; end
      end
      want_stall = p_pend && !gp;
      checks++;
      if (pipe_ready !== gp || lu_ready !== gl || pipe_stall !== want_stall) begin
        errors++;
        $display("FAIL rand_comb[%0d]: got pr=%b lr=%b st=%b, want %b/%b/%b",
                 cyc, pipe_ready, lu_ready, pipe_stall, gp, gl, want_stall);
      end
      checks++;
      if (rf_en !== m_en || rf_addr !== ADDR_W'(m_addr) || rf_data !== m_data) begin
        errors++;
        $display("FAIL rand_write[%0d]: got en=%b addr=%0d data=%h, want %b/%0d/%h",
                 cyc, rf_en, rf_addr, rf_data, m_en, m_addr, m_data);
      end
      checks++;
      if (perf_cnt !== m_perf) begin
        errors++;
        $display("FAIL rand_perf[%0d]: got %0d, want %0d", cyc, perf_cnt, m_perf);
      end
      if (rst) begin
        m_lu_first = 0; m_waited = 0; m_en = 0; m_addr = 0; m_data = 0; m_perf = 0;
        p_pend = 0; l_pend = 0;
      end else begin
        m_en = 0;
        if (gp)      begin m_en = (pipe_addr != 0); m_addr = pipe_addr; m_data = pipe_data; end
        else if (gl) begin m_en = (lu_addr != 0);   m_addr = lu_addr;   m_data = lu_data;   end
        if (PERF_ON && want_stall) m_perf++;
        if (gl || !l_pend) begin
          m_waited   = 0;
          m_lu_first = 0;
        end else if (m_waited < STARVE_MAX) begin
          m_waited++;
          if (m_waited == STARVE_MAX) m_lu_first = 1;
        end
        if (gp) p_pend = 0;
        if (gl) l_pend = 0;
      end
      tick();
      pipe_valid = p_pend;
      lu_valid   = l_pend;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_starvation();
    test_collision();
    test_x0();
    test_reset_mid();
    test_perf();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
